// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, even parity, one stop bit.
// Bit timing comes from a free-running baud_controller ticking 16 times per bit.

module uart_transmitter #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Tx_EN,
    input  logic       Tx_WR,
    input  logic [7:0] Tx_DATA,
    output logic       TxD,
    output logic       Tx_BUSY,
    output logic       Tx_DONE
);
    localparam int unsigned TICK_W = 4;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t              state, state_next;
    logic                tick;
    logic                bit_end;
    logic [TICK_W-1:0]   tick_cnt, tick_cnt_next;
    logic [IDX_W-1:0]    idx, idx_next;
    logic [7:0]          shift, shift_next;
    logic                parity, parity_next;
    logic                txd_next, busy_next, done_next;

    baud_controller #(.CLK_HZ(CLK_HZ)) u_baud (
        .clk           (clk),
        .reset         (reset),
        .baud_select   (baud_select),
        .sample_ENABLE (tick)
    );

    // A bit ends on the tick that wraps the tick counter from 15 to 0.
    assign bit_end = tick && (tick_cnt == TICK_W'(15));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            idx      <= '0;
            shift    <= '0;
            parity   <= 1'b0;
            TxD      <= 1'b1;
            Tx_BUSY  <= 1'b0;
            Tx_DONE  <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_cnt_next;
            idx      <= idx_next;
            shift    <= shift_next;
            parity   <= parity_next;
            TxD      <= txd_next;
            Tx_BUSY  <= busy_next;
            Tx_DONE  <= done_next;
        end
    end

    // Next state; TxD/Tx_BUSY are computed for the state being entered.
    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
        idx_next      = idx;
        shift_next    = shift;
        parity_next   = parity;
        txd_next      = TxD;
        busy_next     = Tx_BUSY;
        done_next     = 1'b0;

        if (state != IDLE && tick) begin
            tick_cnt_next = tick_cnt + TICK_W'(1);
        end

        case (state)
            IDLE: begin
                if (Tx_EN && Tx_WR) begin
                    state_next    = START;
                    shift_next    = Tx_DATA;
                    parity_next   = ^Tx_DATA;
                    tick_cnt_next = '0;
                    idx_next      = '0;
                    txd_next      = 1'b0;
                    busy_next     = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    idx_next   = '0;
                    txd_next   = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == IDX_W'(7)) begin
                        state_next = PARITY;
                        txd_next   = parity;
                    end else begin
                        idx_next   = idx + IDX_W'(1);
                        shift_next = {1'b0, shift[7:1]};
                        txd_next   = shift[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    txd_next   = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    txd_next   = 1'b1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end
endmodule

// Free-running 16x oversampling tick generator; one-cycle pulse per tick.
module baud_controller #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       sample_ENABLE
);
    // Rounded clocks per tick, never below one clock.
    function automatic int unsigned tick_div(input int unsigned baud);
        int unsigned d;
        d = (CLK_HZ + 8 * baud) / (16 * baud);
        return (d == 0) ? 1 : d;
    endfunction

    localparam int unsigned DIV0  = tick_div(300);
    localparam int unsigned DIV1  = tick_div(1200);
    localparam int unsigned DIV2  = tick_div(4800);
    localparam int unsigned DIV3  = tick_div(9600);
    localparam int unsigned DIV4  = tick_div(19200);
    localparam int unsigned DIV5  = tick_div(38400);
    localparam int unsigned DIV6  = tick_div(57600);
    localparam int unsigned DIV7  = tick_div(115200);
    localparam int unsigned CNT_W = (DIV0 > 1) ? $clog2(DIV0) : 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;

    always_comb begin
        last = '0;
        case (baud_select)
            3'd0:    last = CNT_W'(DIV0 - 1);
            3'd1:    last = CNT_W'(DIV1 - 1);
            3'd2:    last = CNT_W'(DIV2 - 1);
            3'd3:    last = CNT_W'(DIV3 - 1);
            3'd4:    last = CNT_W'(DIV4 - 1);
            3'd5:    last = CNT_W'(DIV5 - 1);
            3'd6:    last = CNT_W'(DIV6 - 1);
            default: last = CNT_W'(DIV7 - 1);
        endcase
    end

    // >= so a switch to a faster rate never strands the counter above its limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            sample_ENABLE <= 1'b0;
        end else if (cnt >= last) begin
            cnt           <= '0;
            sample_ENABLE <= 1'b1;
        end else begin
            cnt           <= cnt + CNT_W'(1);
            sample_ENABLE <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// Directed, table-driven bench for uart_transmitter: frame contents, bit timing,
// ignored writes, back-to-back frames, reset abort and per-rate frame length.

module tb_uart_transmitter;
    localparam int unsigned CLK_HZ = 307_200;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
        logic [2:0]  baud;
        int          inj_n;
        logic        inj_wr;
        logic        inj_en;
        logic [7:0]  inj_data;
        string       name;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] baud_select;
    logic       Tx_EN, Tx_WR;
    logic [7:0] Tx_DATA;
    logic       TxD, Tx_BUSY, Tx_DONE;

    int total  = 0;
    int passed = 0;
    int div_tab[8] = '{64, 16, 4, 2, 1, 1, 1, 1};
    vec_t vecs[6];

    uart_transmitter #(.CLK_HZ(CLK_HZ)) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .Tx_EN       (Tx_EN),
        .Tx_WR       (Tx_WR),
        .Tx_DATA     (Tx_DATA),
        .TxD         (TxD),
        .Tx_BUSY     (Tx_BUSY),
        .Tx_DONE     (Tx_DONE)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input bit ok, input string name, input int act, input int exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [7:0] data, input logic [10:0] frame,
                                input logic [2:0] baud, input int inj_n, input logic inj_wr,
                                input logic inj_en, input logic [7:0] inj_data,
                                input string name);
        vec_t v;
        v.data = data; v.frame = frame; v.baud = baud; v.inj_n = inj_n;
        v.inj_wr = inj_wr; v.inj_en = inj_en; v.inj_data = inj_data; v.name = name;
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic write_byte(input logic [7:0] d, input logic en);
        Tx_DATA = d;
        Tx_EN   = en;
        Tx_WR   = 1'b1;
        @(negedge clk);
        Tx_WR   = 1'b0;
    endtask

    task automatic idle_check(input int cycles, input string name);
        bit ok;
        ok = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            if (TxD !== 1'b1 || Tx_BUSY !== 1'b0 || Tx_DONE !== 1'b0) ok = 1'b0;
        end
        check(ok, name, int'(ok), 1);
    endtask

    // Edge n counts from the accepting edge (n=0). Data bit k starts at edge
    // e16+16d*k with e16 in [15d+1,16d]; it is sampled at 24d+16d*k.
    task automatic frame_check(input vec_t v, input bit chain, input logic [7:0] chain_data,
                               output int done_n);
        int d, rise_n, pulses, k;
        d      = div_tab[v.baud];
        rise_n = -1;
        pulses = 0;
        done_n = -1;
        for (int n = 1; n <= 176 * d + 40; n++) begin
            @(negedge clk);
            Tx_WR = 1'b0;
            if (n == 1) begin
                check(TxD == 1'b0, {v.name, " start_txd"}, int'(TxD), 0);
                check(Tx_BUSY == 1'b1, {v.name, " start_busy"}, int'(Tx_BUSY), 1);
            end
            if (rise_n < 0 && n >= 2 && TxD == 1'b1) rise_n = n;
            if (n >= 24 * d && (n - 24 * d) % (16 * d) == 0) begin
                k = (n - 24 * d) / (16 * d);
                if (k <= 9)
                    check(TxD == v.frame[k + 1], $sformatf("%s bit%0d", v.name, k),
                          int'(TxD), int'(v.frame[k + 1]));
            end
            if (v.inj_n == n) begin
                Tx_DATA = v.inj_data;
                Tx_EN   = v.inj_en;
                Tx_WR   = v.inj_wr;
            end
            if (Tx_DONE) begin
                pulses++;
                if (done_n < 0) begin
                    done_n = n;
                    check(Tx_BUSY == 1'b0, {v.name, " done_busy"}, int'(Tx_BUSY), 0);
                    if (chain) begin
                        Tx_DATA = chain_data;
                        Tx_EN   = 1'b1;
                        Tx_WR   = 1'b1;
                    end
                end
            end
            if (done_n >= 0 && n == done_n + 1) break;
        end
        Tx_WR = 1'b0;
        check(done_n >= 175 * d + 1 && done_n <= 176 * d, {v.name, " done_time"},
              done_n, 176 * d);
        check(pulses == 1, {v.name, " done_pulses"}, pulses, 1);
        if (v.frame[1] == 1'b1)
            check(rise_n >= 0 && done_n - rise_n == 160 * d, {v.name, " span160"},
                  done_n - rise_n, 160 * d);
    endtask

    initial begin
        int   dn;
        vec_t v;

        reset       = 1'b1;
        baud_select = 3'd3;
        Tx_EN       = 1'b0;
        Tx_WR       = 1'b0;
        Tx_DATA     = 8'h00;

        vecs[0] = mk(8'h55, 11'b1_0_01010101_0, 3'd3, 0,   1'b0, 1'b1, 8'h00, "x55");
        vecs[1] = mk(8'hA7, 11'b1_1_10100111_0, 3'd3, 0,   1'b0, 1'b1, 8'h00, "xA7");
        vecs[2] = mk(8'h0F, 11'b1_0_00001111_0, 3'd3, 100, 1'b1, 1'b1, 8'h3C, "x0F_wr_mid");
        vecs[3] = mk(8'h01, 11'b1_1_00000001_0, 3'd3, 80,  1'b0, 1'b0, 8'h01, "x01_en_drop");
        vecs[4] = mk(8'h81, 11'b1_0_10000001_0, 3'd5, 0,   1'b0, 1'b1, 8'h00, "x81_b5");
        vecs[5] = mk(8'hFF, 11'b1_0_11111111_0, 3'd6, 0,   1'b0, 1'b1, 8'h00, "xFF_b6");

        repeat (3) @(negedge clk);
        check(TxD == 1'b1, "reset_txd", int'(TxD), 1);
        check(Tx_BUSY == 1'b0, "reset_busy", int'(Tx_BUSY), 0);
        check(Tx_DONE == 1'b0, "reset_done", int'(Tx_DONE), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        write_byte(8'h3C, 1'b0);
        idle_check(60, "en0_ignored");

        foreach (vecs[i]) begin
            baud_select = vecs[i].baud;
            repeat (3) @(negedge clk);
            write_byte(vecs[i].data, 1'b1);
            frame_check(vecs[i], 1'b0, 8'h00, dn);
            repeat (5) @(negedge clk);
        end

        // Back-to-back: second write lands in the Tx_DONE cycle.
        baud_select = 3'd3;
        repeat (3) @(negedge clk);
        write_byte(8'h00, 1'b1);
        v = mk(8'h00, 11'b1_0_00000000_0, 3'd3, 0, 1'b0, 1'b1, 8'h00, "b2b_x00");
        frame_check(v, 1'b1, 8'hFF, dn);
        v = mk(8'hFF, 11'b1_0_11111111_0, 3'd3, 0, 1'b0, 1'b1, 8'h00, "b2b_xFF");
        frame_check(v, 1'b0, 8'h00, dn);
        repeat (5) @(negedge clk);

        // Reset in the middle of data bit 4 of 0x81.
        write_byte(8'h81, 1'b1);
        repeat (24 * 2 + 16 * 2 * 4) @(negedge clk);
        check(TxD == 1'b0 && Tx_BUSY == 1'b1, "abort_pre_bit4", int'(TxD), 0);
        reset = 1'b1;
        @(negedge clk);
        check(TxD == 1'b1, "abort_txd", int'(TxD), 1);
        check(Tx_BUSY == 1'b0, "abort_busy", int'(Tx_BUSY), 0);
        reset = 1'b0;
        idle_check(400, "abort_no_done");
        write_byte(8'h81, 1'b1);
        v = mk(8'h81, 11'b1_0_10000001_0, 3'd3, 0, 1'b0, 1'b1, 8'h00, "after_abort_x81");
        frame_check(v, 1'b0, 8'h00, dn);

        // Frame length at every rate.
        for (int c = 0; c < 8; c++) begin
            baud_select = 3'(c);
            repeat (3) @(negedge clk);
            write_byte(8'h01, 1'b1);
            v = mk(8'h01, 11'b1_1_00000001_0, 3'(c), 0, 1'b0, 1'b1, 8'h00,
                   $sformatf("rate%0d", c));
            frame_check(v, 1'b0, 8'h00, dn);
            repeat (3) @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
